// File: rtl/dff_pipe_if.sv
// dff_pipe_if: control, data and status bundle for dff_pipe.
//
// Parameters
//   WIDTH   data width of each pipeline stage
//   DEPTH   number of pipeline stages (>= 2)
//
// Signals
//   en       advance pipeline this cycle (1) or hold all stages (0)
//   flush    synchronous clear of every stage and valid bit
//   d_in     data into stage 0
//   d_vld    valid qualifier travelling with d_in
//   tap_sel  output stage index; values >= DEPTH read the last stage
//   q        data of the selected stage
//   q_vld    valid bit of the selected stage
//   vld_cnt  number of stages holding a valid word (0..DEPTH)
//   q_n      ~q, present only when DFF_PIPE_QN_EN is defined
//
// Modports
//   master  drives the controls, observes the outputs (user side)
//   slave   the pipeline itself
interface dff_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned SEL_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d_in;
  logic             d_vld;
  logic [SEL_W-1:0] tap_sel;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic [CNT_W-1:0] vld_cnt;
`ifdef DFF_PIPE_QN_EN
  logic [WIDTH-1:0] q_n;
`endif

  modport master (
    output en,
    output flush,
    output d_in,
    output d_vld,
    output tap_sel,
`ifdef DFF_PIPE_QN_EN
    input  q_n,
`endif
    input  q,
    input  q_vld,
    input  vld_cnt
  );

  modport slave (
    input  en,
    input  flush,
    input  d_in,
    input  d_vld,
    input  tap_sel,
`ifdef DFF_PIPE_QN_EN
    output q_n,
`endif
    output q,
    output q_vld,
    output vld_cnt
  );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage clock-enabled delay line with a per-stage
// valid bit, runtime-selectable output tap, synchronous flush and a count of
// valid stages.
//
// Optional feature macro: DFF_PIPE_QN_EN
//   defined   -> bus.q_n = ~bus.q (same tap, same timing)
//   undefined -> no q_n port and no complement logic
//
// Ports
//   clk   rising-edge clock, single domain
//   rst   synchronous, active-high reset; clears all stages and valid bits
//   bus   dff_pipe_if.slave: en, flush, d_in, d_vld, tap_sel in;
//         q, q_vld, vld_cnt (and q_n) out
//
// Edge priority: rst > flush > en > hold. A word accepted on an enabled edge
// shows up at tap k after k+1 enabled edges; stalled edges do not count.
// DEPTH must be at least 2.
module dff_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  dff_pipe_if.slave  bus
);

  localparam int unsigned SEL_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [SEL_W-1:0] LastTap = SEL_W'(DEPTH - 1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  logic [SEL_W-1:0] tap_eff;
  logic [CNT_W-1:0] vld_cnt;

  // Next state: flush clears everything regardless of en; en shifts every
  // stage one place towards the end; otherwise hold (stall, no bubbles).
  // d_in is captured even when d_vld is low.
  always_comb begin
    stage_d = stage_q;
    vld_d   = vld_q;
    if (bus.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_d[i] = '0;
      end
      vld_d = '0;
    end else if (bus.en) begin
      stage_d[0] = bus.d_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
      vld_d = {vld_q[DEPTH-2:0], bus.d_vld};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      stage_q <= stage_d;
      vld_q   <= vld_d;
    end
  end

  // Out-of-range taps (only reachable when DEPTH is not a power of two) read
  // the last stage.
  always_comb begin
    tap_eff = bus.tap_sel;
    if (bus.tap_sel > LastTap) begin
      tap_eff = LastTap;
    end
  end

  // Occupancy over all stages, independent of the selected tap.
  always_comb begin
    vld_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      vld_cnt = vld_cnt + CNT_W'(vld_q[i]);
    end
  end

  assign bus.q       = stage_q[tap_eff];
  assign bus.q_vld   = vld_q[tap_eff];
  assign bus.vld_cnt = vld_cnt;

`ifdef DFF_PIPE_QN_EN
  assign bus.q_n = ~stage_q[tap_eff];
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed scenarios plus randomized traffic checked
// against a history-queue model (newest accepted word at index 0).
module tb_dff_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(3))     bus3 ();

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int n_vec = 0;
  int n_err = 0;

  // Words accepted since the last clear, newest first, {vld, data}.
  logic [WIDTH:0] hist [$];

  function automatic logic [WIDTH:0] model_tap(int k);
    if (k < hist.size()) return hist[k];
    return '0;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    foreach (hist[i]) c += int'(hist[i][WIDTH]);
    return c;
  endfunction

  task automatic model_edge();
    if (rst || bus0.flush) begin
      hist.delete();
    end else if (bus0.en) begin
      hist.push_front({bus0.d_vld, bus0.d_in});
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.en = 1'b1; bus0.flush = 1'b0; bus0.d_in = 8'hA5; bus0.d_vld = 1'b1;
    tick();
    tick();
    for (int t = 0; t < 4; t++) begin
      bus0.tap_sel = 2'(t);
      #1;
      n_vec++;
      if (bus0.q !== 8'h00 || bus0.q_vld !== 1'b0 || bus0.vld_cnt !== 3'd0) begin
        n_err++;
        $display("FAIL reset tap%0d: got q=%h q_vld=%b vld_cnt=%0d, want q=00 q_vld=0 vld_cnt=0",
                 t, bus0.q, bus0.q_vld, bus0.vld_cnt);
      end
`ifdef DFF_PIPE_QN_EN
      n_vec++;
      if (bus0.q_n !== 8'hFF) begin
        n_err++;
        $display("FAIL reset_qn tap%0d: got q_n=%h, want ff", t, bus0.q_n);
      end
`endif
    end
    rst = 1'b0;
    bus0.en = 1'b0;
  endtask

  task automatic feed_1234();
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    bus0.en = 1'b1; bus0.flush = 1'b0; bus0.d_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.d_in = words[i];
      tick();
    end
  endtask

  task automatic test_latency();
    do_reset();
    bus0.tap_sel = 2'd3;
    feed_1234();
    n_vec++;
    if (bus0.q !== 8'h11 || bus0.q_vld !== 1'b1 || bus0.vld_cnt !== 3'd4) begin
      n_err++;
      $display("FAIL latency_fill: got q=%h q_vld=%b vld_cnt=%0d, want q=11 q_vld=1 vld_cnt=4",
               bus0.q, bus0.q_vld, bus0.vld_cnt);
    end
    bus0.d_in = 8'h55;
    tick();
    n_vec++;
    if (bus0.q !== 8'h22 || bus0.vld_cnt !== 3'd4) begin
      n_err++;
      $display("FAIL latency_shift: got q=%h vld_cnt=%0d, want q=22 vld_cnt=4",
               bus0.q, bus0.vld_cnt);
    end
    bus0.en = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    bus0.tap_sel = 2'd3;
    feed_1234();
    bus0.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus0.d_in  = 8'($urandom);
      bus0.d_vld = 1'($urandom);
      tick();
      n_vec++;
      if (bus0.q !== 8'h11 || bus0.q_vld !== 1'b1 || bus0.vld_cnt !== 3'd4) begin
        n_err++;
        $display("FAIL stall_hold c%0d: got q=%h q_vld=%b vld_cnt=%0d, want q=11 q_vld=1 vld_cnt=4",
                 c, bus0.q, bus0.q_vld, bus0.vld_cnt);
      end
    end
    bus0.en = 1'b1; bus0.d_in = 8'h66; bus0.d_vld = 1'b1;
    tick();
    bus0.en = 1'b0;
    n_vec++;
    if (bus0.q !== 8'h22) begin
      n_err++;
      $display("FAIL stall_resume tap3: got q=%h, want 22", bus0.q);
    end
    bus0.tap_sel = 2'd0;
    #1;
    n_vec++;
    if (bus0.q !== 8'h66) begin
      n_err++;
      $display("FAIL stall_resume tap0: got q=%h, want 66", bus0.q);
    end
  endtask

  task automatic test_flush();
    bus0.flush = 1'b1; bus0.en = 1'b1; bus0.d_in = 8'h77; bus0.d_vld = 1'b1;
    tick();
    bus0.flush = 1'b0; bus0.en = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bus0.tap_sel = 2'(t);
      #1;
      n_vec++;
      if (bus0.q_vld !== 1'b0 || bus0.q !== 8'h00 || bus0.vld_cnt !== 3'd0) begin
        n_err++;
        $display("FAIL flush_empty tap%0d: got q=%h q_vld=%b vld_cnt=%0d, want q=00 q_vld=0 vld_cnt=0",
                 t, bus0.q, bus0.q_vld, bus0.vld_cnt);
      end
    end
    bus0.en = 1'b1; bus0.d_in = 8'h77; bus0.d_vld = 1'b1; bus0.tap_sel = 2'd0;
    tick();
    bus0.en = 1'b0;
    n_vec++;
    if (bus0.q !== 8'h77 || bus0.q_vld !== 1'b1 || bus0.vld_cnt !== 3'd1) begin
      n_err++;
      $display("FAIL flush_refill: got q=%h q_vld=%b vld_cnt=%0d, want q=77 q_vld=1 vld_cnt=1",
               bus0.q, bus0.q_vld, bus0.vld_cnt);
    end
  endtask

  task automatic test_bubble();
    logic [7:0] dat [3];
    logic       vl  [3];
    dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'h03;
    vl[0]  = 1'b1;  vl[1]  = 1'b0;  vl[2]  = 1'b1;
    do_reset();
    bus0.tap_sel = 2'd2; bus0.en = 1'b1; bus0.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.d_in = dat[i]; bus0.d_vld = vl[i];
      tick();
    end
    n_vec++;
    if (bus0.q !== 8'h01 || bus0.q_vld !== 1'b1 || bus0.vld_cnt !== 3'd2) begin
      n_err++;
      $display("FAIL bubble_first: got q=%h q_vld=%b vld_cnt=%0d, want q=01 q_vld=1 vld_cnt=2",
               bus0.q, bus0.q_vld, bus0.vld_cnt);
    end
    bus0.d_in = 8'h04; bus0.d_vld = 1'b0;
    tick();
    bus0.en = 1'b0;
    n_vec++;
    if (bus0.q !== 8'h02 || bus0.q_vld !== 1'b0 || bus0.vld_cnt !== 3'd2) begin
      n_err++;
      $display("FAIL bubble_second: got q=%h q_vld=%b vld_cnt=%0d, want q=02 q_vld=0 vld_cnt=2",
               bus0.q, bus0.q_vld, bus0.vld_cnt);
    end
  endtask

  task automatic test_random();
    logic [WIDTH:0] exp;
    for (int c = 0; c < 300; c++) begin
      rst          = ($urandom_range(0, 59) == 0);
      bus0.flush   = ($urandom_range(0, 24) == 0);
      bus0.en      = ($urandom_range(0, 3) != 0);
      bus0.d_in    = 8'($urandom);
      bus0.d_vld   = 1'($urandom);
      bus0.tap_sel = 2'($urandom);
      tick();
      // Tap may change mid-cycle; q must follow without disturbing contents.
      if ($urandom_range(0, 1) == 1) begin
        bus0.tap_sel = 2'($urandom);
        #1;
      end
      exp = model_tap(int'(bus0.tap_sel));
      n_vec++;
      if (bus0.q !== exp[WIDTH-1:0] || bus0.q_vld !== exp[WIDTH] ||
          bus0.vld_cnt !== 3'(model_cnt())) begin
        n_err++;
        $display("FAIL random c%0d tap%0d: got q=%h q_vld=%b vld_cnt=%0d, want q=%h q_vld=%b vld_cnt=%0d",
                 c, bus0.tap_sel, bus0.q, bus0.q_vld, bus0.vld_cnt,
                 exp[WIDTH-1:0], exp[WIDTH], model_cnt());
      end
`ifdef DFF_PIPE_QN_EN
      n_vec++;
      if (bus0.q_n !== ~exp[WIDTH-1:0]) begin
        n_err++;
        $display("FAIL random_qn c%0d: got q_n=%h, want %h", c, bus0.q_n, ~exp[WIDTH-1:0]);
      end
`endif
    end
    rst = 1'b0; bus0.flush = 1'b0; bus0.en = 1'b0;
  endtask

  task automatic test_qn();
`ifdef DFF_PIPE_QN_EN
    bus0.en = 1'b1; bus0.flush = 1'b0; bus0.d_in = 8'h3C; bus0.d_vld = 1'b1;
    bus0.tap_sel = 2'd0;
    tick();
    bus0.en = 1'b0;
    n_vec++;
    if (bus0.q !== 8'h3C || bus0.q_n !== 8'hC3) begin
      n_err++;
      $display("FAIL qn_value: got q=%h q_n=%h, want q=3c q_n=c3", bus0.q, bus0.q_n);
    end
`endif
  endtask

  task automatic test_clamp();
    logic [7:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    do_reset();
    bus3.en = 1'b1; bus3.flush = 1'b0; bus3.d_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus3.d_in = w[i];
      tick();
    end
    bus3.en = 1'b0;
    bus3.tap_sel = 2'd3;
    #1;
    n_vec++;
    if (bus3.q !== w[0] || bus3.q_vld !== 1'b1 || bus3.vld_cnt !== 2'd3) begin
      n_err++;
      $display("FAIL clamp_tap3: got q=%h q_vld=%b vld_cnt=%0d, want q=%h q_vld=1 vld_cnt=3",
               bus3.q, bus3.q_vld, bus3.vld_cnt, w[0]);
    end
    bus3.tap_sel = 2'd0;
    #1;
    n_vec++;
    if (bus3.q !== w[2]) begin
      n_err++;
      $display("FAIL clamp_tap0: got q=%h, want %h", bus3.q, w[2]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus0.en = 1'b0; bus0.flush = 1'b0; bus0.d_in = '0; bus0.d_vld = 1'b0; bus0.tap_sel = '0;
    bus3.en = 1'b0; bus3.flush = 1'b0; bus3.d_in = '0; bus3.d_vld = 1'b0; bus3.tap_sel = '0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bubble();
    test_qn();
    test_random();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion, want finish");
    $fatal(1, "watchdog");
  end

endmodule
